// File: rtl/dense_engine_par_if.sv
// Handshake and LUT/buffer bus bundle for dense_engine_par.
// master = engine side, slave = buffers/LUTs/controller side.
interface dense_engine_par_if #(
  parameter int unsigned IN_COUNT  = 64,
  parameter int unsigned OUT_COUNT = 10,
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned LANES     = 2
);
  localparam int unsigned IAW = $clog2(IN_COUNT);
  localparam int unsigned WAW = $clog2(IN_COUNT * OUT_COUNT);
  localparam int unsigned OAW = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;

  logic                         start;
  logic                         busy;
  logic                         done;
  logic [IAW-1:0]               inAdr;
  logic [DATA_SIZE-1:0]         inData;
  logic [WAW-1:0]               weightAdr;
  logic [LANES*DATA_SIZE-1:0]   weightData;
  logic [OAW-1:0]               biasAdr;
  logic [LANES*DATA_SIZE-1:0]   biasData;
  logic                         outWe;
  logic [OAW-1:0]               outAdr;
  logic [LANES*DATA_SIZE-1:0]   outData;

  modport master (
    input  start, inData, weightData, biasData,
    output busy, done, inAdr, weightAdr, biasAdr, outWe, outAdr, outData
  );

  modport slave (
    output start, inData, weightData, biasData,
    input  busy, done, inAdr, weightAdr, biasAdr, outWe, outAdr, outData
  );
endinterface

// File: rtl/dense_engine_par.sv
// Self-sequenced fully-connected layer engine computing LANES outputs per group.
// Optional macro DENSE_RELU_EN fuses a ReLU after saturation.
module dense_engine_par #(
  parameter int unsigned IN_COUNT  = 64,
  parameter int unsigned OUT_COUNT = 10,
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned LANES     = 2
) (
  input logic                clk,
  input logic                rst,
  dense_engine_par_if.master bus
);
  localparam int unsigned ACC_SIZE = 2 * DATA_SIZE + $clog2(IN_COUNT) + 1;
  localparam int unsigned IAW      = $clog2(IN_COUNT);
  localparam int unsigned WAW      = $clog2(IN_COUNT * OUT_COUNT);
  localparam int unsigned OAW      = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
  localparam int unsigned G        = OUT_COUNT / LANES;
  localparam int unsigned GW       = (G > 1) ? $clog2(G) : 1;
  localparam logic signed [ACC_SIZE-1:0] SatMax =
      (ACC_SIZE'(1) << (DATA_SIZE - 1)) - ACC_SIZE'(1);
  localparam logic signed [ACC_SIZE-1:0] SatMin = ~SatMax;

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StBias, StWrite, StDone} stateT;

  stateT                      stateQ, stateD;
  logic [IAW-1:0]             iQ, iD;
  logic [GW-1:0]              gQ, gD;
  logic [WAW-1:0]             wAdrQ, wAdrD;
  logic [OAW-1:0]             bAdrQ, bAdrD;
  logic [OAW-1:0]             oAdrQ, oAdrD;
  logic signed [ACC_SIZE-1:0] accQ [LANES];
  logic signed [ACC_SIZE-1:0] accD [LANES];
  logic signed [ACC_SIZE-1:0] prodExt [LANES];
  logic signed [ACC_SIZE-1:0] biasExt [LANES];

  function automatic logic [DATA_SIZE-1:0] postProc(input logic signed [ACC_SIZE-1:0] acc);
    logic signed [ACC_SIZE-1:0] sh;
    logic [DATA_SIZE-1:0]       r;
    sh = acc >>> FRAC_BITS;
    if (sh > SatMax)      r = SatMax[DATA_SIZE-1:0];
    else if (sh < SatMin) r = SatMin[DATA_SIZE-1:0];
    else                  r = sh[DATA_SIZE-1:0];
`ifdef DENSE_RELU_EN
    if (r[DATA_SIZE-1]) r = '0;
`endif
    return r;
  endfunction

  for (genvar k = 0; k < LANES; k++) begin : gLane
    logic [DATA_SIZE-1:0]   wRaw, bRaw;
    logic [2*DATA_SIZE-1:0] xExt, wExt, prod;
    assign wRaw = bus.weightData[k*DATA_SIZE +: DATA_SIZE];
    assign bRaw = bus.biasData[k*DATA_SIZE +: DATA_SIZE];
    // Operands pre-extended so the truncated product is the exact signed result.
    assign xExt = {{DATA_SIZE{bus.inData[DATA_SIZE-1]}}, bus.inData};
    assign wExt = {{DATA_SIZE{wRaw[DATA_SIZE-1]}}, wRaw};
    assign prod = xExt * wExt;
    assign prodExt[k] = {{(ACC_SIZE - 2 * DATA_SIZE){prod[2*DATA_SIZE-1]}}, prod};
    assign biasExt[k] = {{(ACC_SIZE - DATA_SIZE){bRaw[DATA_SIZE-1]}}, bRaw} << FRAC_BITS;
    assign bus.outData[k*DATA_SIZE +: DATA_SIZE] =
        (stateQ == StWrite) ? postProc(accQ[k]) : '0;
  end

  always_comb begin
    stateD = stateQ;
    iD     = iQ;
    gD     = gQ;
    wAdrD  = wAdrQ;
    bAdrD  = bAdrQ;
    oAdrD  = oAdrQ;
    accD   = accQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.start) begin
          stateD = StFetch;
          iD     = '0;
          gD     = '0;
          wAdrD  = '0;
          for (int k = 0; k < LANES; k++) accD[k] = '0;
        end
      end
      StFetch: begin
        // Data returned this cycle belongs to address i-1; nothing is valid yet at i=0.
        if (iQ != '0) begin
          for (int k = 0; k < LANES; k++) accD[k] = accQ[k] + prodExt[k];
        end
        if (iQ == IAW'(IN_COUNT - 1)) begin
          stateD = StDrain;
          bAdrD  = OAW'(gQ * LANES);
        end else begin
          iD    = IAW'(iQ + 1);
          wAdrD = WAW'(wAdrQ + OUT_COUNT);
        end
      end
      StDrain: begin
        for (int k = 0; k < LANES; k++) accD[k] = accQ[k] + prodExt[k];
        stateD = StBias;
      end
      StBias: begin
        for (int k = 0; k < LANES; k++) accD[k] = accQ[k] + biasExt[k];
        oAdrD  = OAW'(gQ * LANES);
        stateD = StWrite;
      end
      StWrite: begin
        for (int k = 0; k < LANES; k++) accD[k] = '0;
        if (gQ == GW'(G - 1)) begin
          stateD = StDone;
        end else begin
          gD     = GW'(gQ + 1);
          iD     = '0;
          wAdrD  = WAW'((gQ + 1) * LANES);
          stateD = StFetch;
        end
      end
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ <= StIdle;
      iQ     <= '0;
      gQ     <= '0;
      wAdrQ  <= '0;
      bAdrQ  <= '0;
      oAdrQ  <= '0;
      for (int k = 0; k < LANES; k++) accQ[k] <= '0;
    end else begin
      stateQ <= stateD;
      iQ     <= iD;
      gQ     <= gD;
      wAdrQ  <= wAdrD;
      bAdrQ  <= bAdrD;
      oAdrQ  <= oAdrD;
      for (int k = 0; k < LANES; k++) accQ[k] <= accD[k];
    end
  end

  assign bus.inAdr     = iQ;
  assign bus.weightAdr = wAdrQ;
  assign bus.biasAdr   = bAdrQ;
  assign bus.outAdr    = oAdrQ;
  assign bus.outWe     = (stateQ == StWrite);
  assign bus.done      = (stateQ == StDone);
  assign bus.busy      = (stateQ == StFetch) || (stateQ == StDrain) ||
                         (stateQ == StBias)  || (stateQ == StWrite);
endmodule

// File: tb/tb_dense_engine_par.sv
// Directed bench for dense_engine_par: a 4x4 two-lane instance and a 4x3 one-lane instance.
module tb_dense_engine_par;
`ifdef DENSE_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   nChecks = 0;
  int   nFails = 0;
  int   acceptA, acceptB;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dense_engine_par_if #(.IN_COUNT(4), .OUT_COUNT(4), .DATA_SIZE(16), .LANES(2)) busA ();
  dense_engine_par_if #(.IN_COUNT(4), .OUT_COUNT(3), .DATA_SIZE(16), .LANES(1)) busB ();

  dense_engine_par #(
    .IN_COUNT(4), .OUT_COUNT(4), .DATA_SIZE(16), .FRAC_BITS(8), .LANES(2)
  ) dutA (
    .clk(clk),
    .rst(rst),
    .bus(busA)
  );

  dense_engine_par #(
    .IN_COUNT(4), .OUT_COUNT(3), .DATA_SIZE(16), .FRAC_BITS(8), .LANES(1)
  ) dutB (
    .clk(clk),
    .rst(rst),
    .bus(busB)
  );

  logic [15:0] inMem [4];
  logic [15:0] wMemA [16];
  logic [15:0] bMemA [4];
  logic [15:0] wMemB [16];
  logic [15:0] bMemB [4];

  // One-cycle-latency buffer/LUT models.
  always @(posedge clk) begin
    busA.inData     <= inMem[busA.inAdr];
    busA.weightData <= {wMemA[int'(busA.weightAdr) + 1], wMemA[busA.weightAdr]};
    busA.biasData   <= {bMemA[int'(busA.biasAdr) + 1], bMemA[busA.biasAdr]};
    busB.inData     <= inMem[busB.inAdr];
    busB.weightData <= wMemB[busB.weightAdr];
    busB.biasData   <= bMemB[busB.biasAdr];
  end

  logic [31:0] wrDatA [$];
  int          wrAdrA [$];
  int          wrCycA [$];
  int          doneA  [$];
  logic [15:0] wrDatB [$];
  int          wrAdrB [$];
  int          doneB  [$];

  always @(negedge clk) begin
    if (busA.outWe) begin
      wrDatA.push_back(busA.outData);
      wrAdrA.push_back(int'(busA.outAdr));
      wrCycA.push_back(cyc);
    end
    if (busA.done) doneA.push_back(cyc);
    if (busB.outWe) begin
      wrDatB.push_back(busB.outData);
      wrAdrB.push_back(int'(busB.outAdr));
    end
    if (busB.done) doneB.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic fillA(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b);
    for (int i = 0; i < 4; i++) inMem[i] = x;
    for (int i = 0; i < 16; i++) wMemA[i] = w;
    for (int i = 0; i < 4; i++) bMemA[i] = b;
  endtask

  task automatic clearA();
    wrDatA.delete(); wrAdrA.delete(); wrCycA.delete(); doneA.delete();
  endtask

  // Returns at the negedge of the first cycle after the accept edge (k=0).
  task automatic startA();
    @(negedge clk);
    busA.start = 1'b1;
    acceptA = cyc + 1;
    @(negedge clk);
    busA.start = 1'b0;
  endtask

  task automatic waitDoneA(input int n, input int budget);
    int t = 0;
    while (doneA.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("doneSeenA", doneA.size(), n);
  endtask

  task automatic passA();
    clearA();
    startA();
    waitDoneA(1, 40);
    repeat (3) @(negedge clk);
  endtask

  logic [15:0] e16;
  int          wExp [11] = '{0, 4, 8, 12, -1, -1, -1, 2, 6, 10, 14};
  logic [15:0] expB [3]  = '{16'd6, 16'd22, 16'd38};

  initial begin
    busA.start = 1'b0;
    busB.start = 1'b0;
    fillA(16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 16; i++) wMemB[i] = '0;
    for (int i = 0; i < 4; i++) bMemB[i] = '0;
    repeat (3) @(negedge clk);
    check("rstA", {busA.busy, busA.done, busA.outWe, busA.inAdr, busA.weightAdr,
                   busA.biasAdr, busA.outAdr, busA.outData}, '0);
    check("rstB", {busB.busy, busB.done, busB.outWe, busB.inAdr, busB.weightAdr,
                   busB.biasAdr, busB.outAdr, busB.outData}, '0);
    rst = 1'b1;
    @(negedge clk);

    // Basic pass: 4 * (1.0 * 0.5) = 2.0
    fillA(16'h0100, 16'h0080, 16'h0000);
    passA();
    check("t1DoneLat", doneA[0] - acceptA, 14);
    check("t1NWr", wrDatA.size(), 2);
    check("t1WrLat", wrCycA[0] - acceptA, 6);
    check("t1Adr0", wrAdrA[0], 0);
    check("t1Dat0", wrDatA[0], 32'h0200_0200);
    check("t1Adr1", wrAdrA[1], 2);
    check("t1Dat1", wrDatA[1], 32'h0200_0200);

    // Negative result with bias: -4.0 + 1.0 = -3.0
    fillA(16'h0100, 16'hFF00, 16'h0100);
    passA();
    e16 = Relu ? 16'h0000 : 16'hFD00;
    check("t2Dat0", wrDatA[0], {e16, e16});
    check("t2Dat1", wrDatA[1], {e16, e16});

    fillA(16'h7FFF, 16'h7FFF, 16'h0000);
    passA();
    check("t3PosSat", wrDatA[1], 32'h7FFF_7FFF);

    fillA(16'h7FFF, 16'h8000, 16'h0000);
    passA();
    e16 = Relu ? 16'h0000 : 16'h8000;
    check("t3NegSat", wrDatA[0], {e16, e16});

    // Distinct raw weights W[i][o] = i + 4*o, row-major at i*4 + o.
    fillA(16'h0100, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++)
      for (int o = 0; o < 4; o++) wMemA[i*4 + o] = 16'(i + 4 * o);
    clearA();
    startA();
    for (int k = 0; k < 11; k++) begin
      if (wExp[k] >= 0) check($sformatf("t4WAdr%0d", k), busA.weightAdr, wExp[k]);
      @(negedge clk);
    end
    waitDoneA(1, 40);
    check("t4Dat0", wrDatA[0], {16'd22, 16'd6});
    check("t4Dat1", wrDatA[1], {16'd54, 16'd38});

    // Start pulsed during group 1 fetch is ignored.
    fillA(16'h0100, 16'h0080, 16'h0000);
    clearA();
    startA();
    repeat (8) @(negedge clk);
    busA.start = 1'b1;
    @(negedge clk);
    busA.start = 1'b0;
    waitDoneA(1, 40);
    repeat (30) @(negedge clk);
    check("t5NDone", doneA.size(), 1);
    check("t5NWr", wrDatA.size(), 2);
    check("t5DoneLat", doneA[0] - acceptA, 14);

    // Reset during group 0 fetch aborts the pass.
    clearA();
    startA();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6Rst", {busA.busy, busA.done, busA.outWe, busA.inAdr, busA.weightAdr,
                    busA.biasAdr, busA.outAdr, busA.outData}, '0);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check("t6NWr", wrDatA.size(), 0);
    check("t6NDone", doneA.size(), 0);
    passA();
    check("t6Recover", wrDatA[1], 32'h0200_0200);

    // Single-lane, three groups, start held high across DONE.
    for (int i = 0; i < 4; i++) inMem[i] = 16'h0100;
    for (int i = 0; i < 4; i++)
      for (int o = 0; o < 3; o++) wMemB[i*3 + o] = 16'(i + 4 * o);
    wrDatB.delete(); wrAdrB.delete(); doneB.delete();
    @(negedge clk);
    busB.start = 1'b1;
    acceptB = cyc + 1;
    begin
      int t = 0;
      while (doneB.size() < 1 && t < 40) begin @(negedge clk); t++; end
      t = 0;
      while (!busB.busy && t < 10) begin @(negedge clk); t++; end
      busB.start = 1'b0;
      t = 0;
      while (doneB.size() < 2 && t < 40) begin @(negedge clk); t++; end
    end
    repeat (3) @(negedge clk);
    check("bNDone", doneB.size(), 2);
    check("bDoneLat", doneB[0] - acceptB, 21);
    check("bRetrig", doneB[1] - doneB[0], 23);
    check("bNWr", wrDatB.size(), 6);
    for (int j = 0; j < 6; j++) begin
      check($sformatf("bAdr%0d", j), wrAdrB[j], j % 3);
      check($sformatf("bDat%0d", j), wrDatB[j], expB[j % 3]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
